// File: rtl/stratixii_lvds_rx_align_ctrl.sv
// stratixii_lvds_rx_align_ctrl
// Per-channel LVDS receiver training sequencer: optional DPA reset and lock
// wait, FIFO and bitslip resets, then bitslip until the deserialized word
// matches the training pattern for match_count consecutive strobes.
module stratixii_lvds_rx_align_ctrl #(
    parameter int unsigned number_of_channels     = 1,
    parameter int unsigned deserialization_factor = 4,
    parameter string       enable_dpa_mode        = "OFF",
    parameter int unsigned data_align_rollover    = deserialization_factor,
    parameter logic [deserialization_factor-1:0] training_pattern = 4'b1100,
    parameter int unsigned match_count            = 4,
    parameter int unsigned settle_words           = 2,
    parameter int unsigned lock_timeout           = 256,
    localparam int unsigned CH_W = (number_of_channels > 1) ? $clog2(number_of_channels) : 1
) (
    input  logic                                                 rx_fastclk,
    input  logic                                                 rx_reset,
    input  logic                                                 rx_enable,
    input  logic                                                 start,
    input  logic [deserialization_factor*number_of_channels-1:0] rx_out,
    input  logic [number_of_channels-1:0]                        rx_dpa_locked,
    input  logic [number_of_channels-1:0]                        rx_cda_max,
    output logic [number_of_channels-1:0]                        rx_dpll_reset,
    output logic [number_of_channels-1:0]                        rx_fifo_reset,
    output logic [number_of_channels-1:0]                        rx_cda_reset,
    output logic [number_of_channels-1:0]                        rx_channel_data_align,
    output logic                                                 busy,
    output logic                                                 done,
    output logic [number_of_channels-1:0]                        aligned,
    output logic [number_of_channels-1:0]                        align_error,
    output logic [CH_W-1:0]                                      cur_channel
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_DPA,
        S_WAIT_LOCK,
        S_RST_FIFO,
        S_RST_CDA,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_NEXT,
        S_DONE
    } state_t;

    localparam bit          DPA_ON   = (enable_dpa_mode == "ON");
    localparam state_t      FIRST_ST = DPA_ON ? S_RST_DPA : S_RST_CDA;
    localparam logic [15:0] LOCK_TO  = 16'(lock_timeout);
    localparam logic [15:0] SETTLE_N = 16'(settle_words);
    localparam logic [3:0]  ROLL_N   = 4'(data_align_rollover);
    localparam logic [3:0]  MATCH_N  = 4'(match_count);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(number_of_channels - 1);

    localparam int unsigned NCH = number_of_channels;
    localparam int unsigned DF  = deserialization_factor;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [15:0]       wait_q, wait_d;
    logic [3:0]        slip_cnt_q, slip_cnt_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [CH_W-1:0]   cur_channel_q, cur_channel_d;

    logic [NCH-1:0]    rx_dpll_reset_q, rx_dpll_reset_d;
    logic [NCH-1:0]    rx_fifo_reset_q, rx_fifo_reset_d;
    logic [NCH-1:0]    rx_cda_reset_q, rx_cda_reset_d;
    logic [NCH-1:0]    rx_channel_data_align_q, rx_channel_data_align_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NCH-1:0]    aligned_q, aligned_d;
    logic [NCH-1:0]    align_error_q, align_error_d;

    // Sequencing events passed from the next-state logic to the status logic.
    logic              ev_start;
    logic              ev_aligned;
    logic              ev_error;
    logic              ev_done;

    logic [DF-1:0]     cur_word;
    logic              cur_locked;

    // The max-bitslip flag is informational only and never steers the flow.
    logic              cda_max_unused;
    assign cda_max_unused = ^rx_cda_max;

    // Select the word and lock flag of the channel under training.
    always_comb begin
        cur_word   = rx_out[cur_channel_q*DF +: DF];
        cur_locked = rx_dpa_locked[cur_channel_q];
    end

    // State register and all registered outputs.
    always_ff @(posedge rx_fastclk) begin
        if (rx_reset) begin
            state_q                 <= S_IDLE;
            phase_q                 <= '0;
            wait_q                  <= '0;
            slip_cnt_q              <= '0;
            match_cnt_q             <= '0;
            cur_channel_q           <= '0;
            rx_dpll_reset_q         <= '0;
            rx_fifo_reset_q         <= '0;
            rx_cda_reset_q          <= '0;
            rx_channel_data_align_q <= '0;
            busy_q                  <= 1'b0;
            done_q                  <= 1'b0;
            aligned_q               <= '0;
            align_error_q           <= '0;
        end else begin
            state_q                 <= state_d;
            phase_q                 <= phase_d;
            wait_q                  <= wait_d;
            slip_cnt_q              <= slip_cnt_d;
            match_cnt_q             <= match_cnt_d;
            cur_channel_q           <= cur_channel_d;
            rx_dpll_reset_q         <= rx_dpll_reset_d;
            rx_fifo_reset_q         <= rx_fifo_reset_d;
            rx_cda_reset_q          <= rx_cda_reset_d;
            rx_channel_data_align_q <= rx_channel_data_align_d;
            busy_q                  <= busy_d;
            done_q                  <= done_d;
            aligned_q               <= aligned_d;
            align_error_q           <= align_error_d;
        end
    end

    // Next-state, counters and channel index.
    always_comb begin
        state_d       = state_q;
        phase_d       = '0;
        wait_d        = '0;
        slip_cnt_d    = slip_cnt_q;
        match_cnt_d   = match_cnt_q;
        cur_channel_d = cur_channel_q;
        ev_start      = 1'b0;
        ev_aligned    = 1'b0;
        ev_error      = 1'b0;
        ev_done       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ev_start      = 1'b1;
                    cur_channel_d = '0;
                    state_d       = FIRST_ST;
                end
            end

            S_RST_DPA: begin
                if (phase_q == 2'd3) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end

            S_WAIT_LOCK: begin
                wait_d = wait_q;
                // Lock is tested first so it wins over a coincident timeout.
                if (cur_locked) begin
                    wait_d  = '0;
                    state_d = S_RST_FIFO;
                end else if (rx_enable) begin
                    if (({1'b0, wait_q} + 17'd1) == {1'b0, LOCK_TO}) begin
                        ev_error = 1'b1;
                        wait_d   = '0;
                        state_d  = S_NEXT;
                    end else if (wait_q != '1) begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end

            S_RST_FIFO: begin
                if (phase_q == 2'd1) begin
                    state_d = S_RST_CDA;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end

            S_RST_CDA: begin
                if (phase_q == 2'd1) begin
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                    state_d     = S_SETTLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end

            S_SETTLE: begin
                if (SETTLE_N == 16'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q;
                    if (rx_enable) begin
                        if (({1'b0, wait_q} + 17'd1) == {1'b0, SETTLE_N}) begin
                            wait_d  = '0;
                            state_d = S_CHECK;
                        end else if (wait_q != '1) begin
                            wait_d = wait_q + 16'd1;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (rx_enable) begin
                    if (cur_word == training_pattern) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        // Checked before the rollover test, so a match on the
                        // last slip position still counts as aligned.
                        if (({1'b0, match_cnt_q} + 5'd1) == {1'b0, MATCH_N}) begin
                            ev_aligned = 1'b1;
                            state_d    = S_NEXT;
                        end
                    end else begin
                        match_cnt_d = '0;
                        if (slip_cnt_q == ROLL_N) begin
                            ev_error = 1'b1;
                            state_d  = S_NEXT;
                        end else begin
                            state_d = S_SLIP;
                        end
                    end
                end
            end

            S_SLIP: begin
                // Phases 0-1 drive the request, phase 2 is the low gap.
                if (phase_q == 2'd2) begin
                    slip_cnt_d = slip_cnt_q + 4'd1;
                    state_d    = S_SETTLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end

            S_NEXT: begin
                if (cur_channel_q == LAST_CH) begin
                    ev_done = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cur_channel_d = cur_channel_q + CH_W'(1);
                    state_d       = FIRST_ST;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: control pulses follow the current state one cycle late,
    // status flags follow the sequencing events.
    always_comb begin
        rx_dpll_reset_d         = '0;
        rx_fifo_reset_d         = '0;
        rx_cda_reset_d          = '0;
        rx_channel_data_align_d = '0;
        busy_d                  = busy_q;
        done_d                  = done_q;
        aligned_d               = aligned_q;
        align_error_d           = align_error_q;

        case (state_q)
            S_RST_DPA:  rx_dpll_reset_d[cur_channel_q] = 1'b1;
            S_RST_FIFO: rx_fifo_reset_d[cur_channel_q] = 1'b1;
            S_RST_CDA:  rx_cda_reset_d[cur_channel_q]  = 1'b1;
            S_SLIP:     rx_channel_data_align_d[cur_channel_q] = (phase_q != 2'd2);
            default: ;
        endcase

        if (ev_start) begin
            busy_d        = 1'b1;
            done_d        = 1'b0;
            aligned_d     = '0;
            align_error_d = '0;
        end
        if (ev_aligned) begin
            aligned_d[cur_channel_q] = 1'b1;
        end
        if (ev_error) begin
            align_error_d[cur_channel_q] = 1'b1;
        end
        if (ev_done) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign rx_dpll_reset         = rx_dpll_reset_q;
    assign rx_fifo_reset         = rx_fifo_reset_q;
    assign rx_cda_reset          = rx_cda_reset_q;
    assign rx_channel_data_align = rx_channel_data_align_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign aligned               = aligned_q;
    assign align_error           = align_error_q;
    assign cur_channel           = cur_channel_q;

endmodule

// File: tb/tb_stratixii_lvds_rx_align_ctrl.sv
// Directed bench for stratixii_lvds_rx_align_ctrl: one DPA-off and one
// DPA-on instance, a bitslip receiver model and hand-derived expectations.
`timescale 1ns/1ps
module tb_stratixii_lvds_rx_align_ctrl;

    logic       clk;
    logic       rx_reset;
    logic       rx_enable;
    logic       start_off, start_on;
    logic [7:0] rx_out_off, rx_out_on;
    logic [1:0] locked_off, locked_on, cda_max;

    logic [1:0] dpll_off, fifo_off, cda_off, align_off, aligned_off, err_off;
    logic       busy_off, done_off;
    logic [0:0] cur_off;
    logic [1:0] dpll_on, fifo_on, cda_on, align_on, aligned_on, err_on;
    logic       busy_on, done_on;
    logic [0:0] cur_on;

    stratixii_lvds_rx_align_ctrl #(
        .number_of_channels(2),
        .enable_dpa_mode("OFF")
    ) dut_off (
        .rx_fastclk(clk), .rx_reset(rx_reset), .rx_enable(rx_enable), .start(start_off),
        .rx_out(rx_out_off), .rx_dpa_locked(locked_off), .rx_cda_max(cda_max),
        .rx_dpll_reset(dpll_off), .rx_fifo_reset(fifo_off), .rx_cda_reset(cda_off),
        .rx_channel_data_align(align_off), .busy(busy_off), .done(done_off),
        .aligned(aligned_off), .align_error(err_off), .cur_channel(cur_off)
    );

    stratixii_lvds_rx_align_ctrl #(
        .number_of_channels(2),
        .enable_dpa_mode("ON"),
        .lock_timeout(8)
    ) dut_on (
        .rx_fastclk(clk), .rx_reset(rx_reset), .rx_enable(rx_enable), .start(start_on),
        .rx_out(rx_out_on), .rx_dpa_locked(locked_on), .rx_cda_max(cda_max),
        .rx_dpll_reset(dpll_on), .rx_fifo_reset(fifo_on), .rx_cda_reset(cda_on),
        .rx_channel_data_align(align_on), .busy(busy_on), .done(done_on),
        .aligned(aligned_on), .align_error(err_on), .cur_channel(cur_on)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Word strobe: free-running 1-in-4, or single strobes on request.
    bit auto_en  = 1'b1;
    int man_req  = 0;
    int man_done = 0;
    initial begin
        int ph;
        ph = 0;
        rx_enable = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en) begin
                ph = (ph + 1) % 4;
                rx_enable = (ph == 0);
            end else if (man_done != man_req) begin
                rx_enable = 1'b1;
                man_done++;
            end else begin
                rx_enable = 1'b0;
            end
        end
    end

    // Receiver model for dut_off: each rising slip edge advances the word
    // position, a bitslip reset returns it to 0; the pattern appears once
    // the position reaches need[c].
    int need[2];
    int pos[2];
    int rises_off[2], hi_align_off[2], hi_cda_off[2], hi_fifo_off[2], hi_dpll_off[2];
    int hi_cda_on[2], hi_fifo_on[2], hi_dpll_on[2];
    logic [1:0] prev_align;
    initial begin
        rx_out_off = 8'h66;
        prev_align = 2'b00;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (align_off[c] && !prev_align[c]) rises_off[c]++;
                if (align_off[c]) hi_align_off[c]++;
                if (cda_off[c])   hi_cda_off[c]++;
                if (fifo_off[c])  hi_fifo_off[c]++;
                if (dpll_off[c])  hi_dpll_off[c]++;
                if (cda_on[c])    hi_cda_on[c]++;
                if (fifo_on[c])   hi_fifo_on[c]++;
                if (dpll_on[c])   hi_dpll_on[c]++;
                if (cda_off[c])
                    pos[c] = 0;
                else if (align_off[c] && !prev_align[c])
                    pos[c]++;
                rx_out_off[c*4 +: 4] = (pos[c] >= need[c]) ? 4'b1100 : 4'b0110;
            end
            prev_align = align_off;
        end
    end

    task automatic wait_done_off();
        for (int k = 0; k < 3000 && !done_off; k++) step(1);
    endtask

    task automatic run_off(input int n0, input int n1);
        need[0] = n0;
        need[1] = n1;
        start_off = 1'b1;
        step(1);
        start_off = 1'b0;
        wait_done_off();
    endtask

    initial begin
        int r0, r1, a0, c0, c1, d0, d1, f0, f1;
        rx_reset   = 1'b1;
        start_off  = 1'b0;
        start_on   = 1'b0;
        rx_out_on  = 8'b1100_1100;
        locked_off = 2'b11;
        locked_on  = 2'b10;
        cda_max    = 2'b00;
        need[0] = 0;
        need[1] = 0;
        step(3);
        rx_reset = 1'b0;
        step(1);

        check_eq("rst_ctrl_off", {dpll_off, fifo_off, cda_off, align_off}, 0);
        check_eq("rst_stat_off", {busy_off, done_off, aligned_off, err_off, cur_off}, 0);
        check_eq("rst_ctrl_on",  {dpll_on, fifo_on, cda_on, align_on}, 0);
        check_eq("rst_stat_on",  {busy_on, done_on, aligned_on, err_on, cur_on}, 0);

        // Ideal data, DPA off: no slips, both channels aligned.
        r0 = rises_off[0]; r1 = rises_off[1];
        c0 = hi_cda_off[0]; c1 = hi_cda_off[1];
        d0 = hi_dpll_off[0] + hi_dpll_off[1]; f0 = hi_fifo_off[0] + hi_fifo_off[1];
        start_off = 1'b1;
        step(1);
        start_off = 1'b0;
        check_eq("t1_busy_after_start", busy_off, 1);
        check_eq("t1_cda_not_yet", cda_off, 2'b00);
        step(1);
        check_eq("t1_cda_first_pulse", cda_off, 2'b01);
        wait_done_off();
        check_eq("t1_done", done_off, 1);
        check_eq("t1_busy", busy_off, 0);
        check_eq("t1_aligned", aligned_off, 2'b11);
        check_eq("t1_err", err_off, 2'b00);
        check_eq("t1_slips", (rises_off[0] - r0) + (rises_off[1] - r1), 0);
        check_eq("t1_cda_cycles0", hi_cda_off[0] - c0, 2);
        check_eq("t1_cda_cycles1", hi_cda_off[1] - c1, 2);
        check_eq("t1_no_dpa_fifo", (hi_dpll_off[0] + hi_dpll_off[1] - d0) + (hi_fifo_off[0] + hi_fifo_off[1] - f0), 0);
        step(5);
        check_eq("t1_hold", {done_off, aligned_off}, 3'b111);

        // Two slips on ch0, with a start pulse ignored while busy on ch1.
        r0 = rises_off[0]; r1 = rises_off[1]; a0 = hi_align_off[0];
        need[0] = 2;
        need[1] = 0;
        start_off = 1'b1;
        step(1);
        start_off = 1'b0;
        for (int k = 0; k < 3000 && cur_off != 1'b1; k++) step(1);
        step(12);
        start_off = 1'b1;
        step(1);
        start_off = 1'b0;
        check_eq("t2_busy_kept", busy_off, 1);
        check_eq("t2_aligned0_kept", aligned_off[0], 1);
        check_eq("t2_cur_kept", cur_off, 1);
        wait_done_off();
        check_eq("t2_done", done_off, 1);
        check_eq("t2_aligned", aligned_off, 2'b11);
        check_eq("t2_err", err_off, 2'b00);
        check_eq("t2_rises0", rises_off[0] - r0, 2);
        check_eq("t2_rises1", rises_off[1] - r1, 0);
        check_eq("t2_slip_width", hi_align_off[0] - a0, 4);

        // Pattern never matches on ch0: four slips then error.
        r0 = rises_off[0];
        run_off(99, 0);
        check_eq("t3_done", done_off, 1);
        check_eq("t3_rises0", rises_off[0] - r0, 4);
        check_eq("t3_aligned", aligned_off, 2'b10);
        check_eq("t3_err", err_off, 2'b01);

        // Match appears on the last allowed slip position: alignment wins.
        r0 = rises_off[0];
        run_off(4, 0);
        check_eq("t3b_rises0", rises_off[0] - r0, 4);
        check_eq("t3b_aligned", aligned_off, 2'b11);
        check_eq("t3b_err", err_off, 2'b00);

        // DPA on, ch0 never locks: timeout after exactly 8 strobes.
        auto_en = 1'b0;
        step(2);
        d0 = hi_dpll_on[0]; d1 = hi_dpll_on[1];
        f0 = hi_fifo_on[0]; f1 = hi_fifo_on[1];
        c0 = hi_cda_on[0];  c1 = hi_cda_on[1];
        start_on = 1'b1;
        step(1);
        start_on = 1'b0;
        check_eq("t4_busy", busy_on, 1);
        step(8);
        check_eq("t4_dpll_cycles0", hi_dpll_on[0] - d0, 4);
        for (int i = 0; i < 7; i++) begin
            man_req++;
            step(3);
        end
        check_eq("t4_no_err_7", err_on[0], 0);
        man_req++;
        step(3);
        check_eq("t4_err_8", err_on[0], 1);
        check_eq("t4_cur_next", cur_on, 1);
        auto_en = 1'b1;
        for (int k = 0; k < 3000 && !done_on; k++) step(1);
        check_eq("t4_done", done_on, 1);
        check_eq("t4_aligned", aligned_on, 2'b10);
        check_eq("t4_err", err_on, 2'b01);
        check_eq("t4_ch0_fifo_cda", (hi_fifo_on[0] - f0) + (hi_cda_on[0] - c0), 0);
        check_eq("t4_ch1_dpll", hi_dpll_on[1] - d1, 4);
        check_eq("t4_ch1_fifo", hi_fifo_on[1] - f1, 2);
        check_eq("t4_ch1_cda", hi_cda_on[1] - c1, 2);

        // Reset during the first slip cycle.
        need[0] = 99;
        need[1] = 0;
        start_off = 1'b1;
        step(1);
        start_off = 1'b0;
        for (int k = 0; k < 3000 && !align_off[0]; k++) step(1);
        check_eq("t5_in_slip", align_off[0], 1);
        rx_reset = 1'b1;
        step(1);
        check_eq("t5_align", align_off, 2'b00);
        check_eq("t5_busy", busy_off, 0);
        check_eq("t5_cur", cur_off, 0);
        check_eq("t5_done_on_cleared", done_on, 0);
        rx_reset = 1'b0;
        step(6);
        check_eq("t5_stays_idle", {busy_off, align_off, cda_off}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stratixii_lvds_rx_align_ctrl.md
# stratixii_lvds_rx_align_ctrl

Training sequencer for the Stratix II LVDS receiver. It walks through the receiver channels one at a time. For each channel it resets the DPA and waits for lock, resets the phase-compensation FIFO and the bitslip logic, then pulses bitslip until the deserialized word matches a known training pattern. It sits between link-bringup control and the receiver's per-channel control pins, and it observes `rx_out`, `rx_dpa_locked` and `rx_cda_max`.

## Interface
- `number_of_channels`, 1: receiver channels under control.
- `deserialization_factor`, 4: bits per channel word.
- `enable_dpa_mode`, "OFF": "ON" runs the DPA-reset, lock-wait and FIFO-reset steps; "OFF" skips them.
- `data_align_rollover`, `deserialization_factor`: bitslip positions before rollover.
- `training_pattern`, 4'b1100: expected per-channel word, `deserialization_factor` bits.
- `match_count`, 4: consecutive matching words needed to declare alignment (1..15).
- `settle_words`, 2: word strobes to ignore after any reset or slip (0..15).
- `lock_timeout`, 256: word strobes to wait for DPA lock before flagging an error (1..65535).
- `CH_W`, local: `$clog2(number_of_channels)`, minimum 1.
- `rx_fastclk`, in, 1: the single clock. Every register is on its rising edge.
- `rx_reset`, in, 1: synchronous, active-high reset.
- `rx_enable`, in, 1: word strobe, a one-cycle pulse per word. `rx_out` is valid on the cycle it is high.
- `start`, in, 1: begin training. Sampled only in IDLE or DONE.
- `rx_out`, in, `deserialization_factor*number_of_channels`: receiver parallel data. Channel c occupies bits [c*deserialization_factor +: deserialization_factor].
- `rx_dpa_locked`, in, `number_of_channels`: per-channel DPA lock.
- `rx_cda_max`, in, `number_of_channels`: per-channel maximum-bitslip flag.
- `rx_dpll_reset`, out, `number_of_channels`: DPA reset.
- `rx_fifo_reset`, out, `number_of_channels`: FIFO reset.
- `rx_cda_reset`, out, `number_of_channels`: bitslip reset.
- `rx_channel_data_align`, out, `number_of_channels`: bitslip request.
- `busy`, out, 1: training is in progress.
- `done`, out, 1: every channel has been processed.
- `aligned`, out, `number_of_channels`: the channel achieved alignment.
- `align_error`, out, `number_of_channels`: the channel hit a lock timeout or exhausted its slips.
- `cur_channel`, out, `CH_W`: index of the channel being trained.

## Operation
- All outputs are registered. Only bit `cur_channel` of each per-channel control bus is ever driven high; every other bit stays 0.
- **IDLE / DONE**
  - In either state, `start`=1 moves to RST_DPA, or to RST_CDA when DPA mode is "OFF".
  - On that transition: `cur_channel`←0, `aligned`←0, `align_error`←0, `done`←0, `busy`←1.
  - `start` is ignored while `busy`=1.
- **RST_DPA**: `rx_dpll_reset[ch]`=1 for exactly 4 cycles, then WAIT_LOCK with the timeout counter at 0.
- **WAIT_LOCK**
  - If `rx_dpa_locked[ch]`=1, go to RST_FIFO.
  - Otherwise the counter increments on each `rx_enable`. When it reaches `lock_timeout`, set `align_error[ch]`←1 and go to NEXT.
- **RST_FIFO**: `rx_fifo_reset[ch]`=1 for 2 cycles, then RST_CDA.
- **RST_CDA**: `rx_cda_reset[ch]`=1 for 2 cycles. Set `slip_cnt`←0 and `match_cnt`←0, then SETTLE.
- **SETTLE**: count `settle_words` strobes, then CHECK. With `settle_words`=0, go to CHECK on the next cycle.
- **CHECK**: act on each `rx_enable` as follows.
  - Word equals `training_pattern`: `match_cnt`++. When `match_cnt`+1 reaches `match_count`, set `aligned[ch]`←1 and go to NEXT.
  - Word mismatches: `match_cnt`←0.
    - If `slip_cnt` equals `data_align_rollover`, every position has been tried: set `align_error[ch]`←1 and go to NEXT.
    - Otherwise go to SLIP.
- **SLIP**
  - `rx_channel_data_align[ch]`=1 for exactly 2 cycles, then 0 for at least 1 cycle. This produces a clean rising edge per slip.
  - Then `slip_cnt`++ and go to SETTLE.
  - `rx_cda_max` is informational only. When `slip_cnt`=`data_align_rollover`-1 after the increment, it must read 1; a mismatch with this does not change the flow.
- **NEXT**
  - If `cur_channel`=`number_of_channels`-1: go to DONE with `done`←1 and `busy`←0.
  - Otherwise `cur_channel`++ and go to RST_DPA, or RST_CDA when DPA mode is "OFF".
- **Counter widths**
  - `slip_cnt` is 4 bits and `match_cnt` is 4 bits.
  - The timeout and settle counters are 16 bits and saturate rather than wrap.

## Timing
- **Reset**: `rx_reset`=1 at a clock edge puts the FSM in IDLE. On the next edge after assertion, every output is 0: all control buses, `busy`, `done`, `aligned`, `align_error`, and `cur_channel`. This applies mid-operation, including mid-pulse.
- `start` sampled high at edge N: `busy`=1 after edge N, and the first reset pulse is high from edge N+1.
- A `rx_enable` coincident with a state entry is not counted by that state. Counting begins on the following strobe.
- `rx_dpa_locked` already high on entry to WAIT_LOCK: RST_FIFO follows one cycle later.
- Lock and timeout on the same strobe: lock wins.
- Match completion on the final allowed slip position: alignment wins over error.
- `done` and `aligned` hold until the next `start` or reset.

## Test plan
- **DPA off, two channels, ideal data**: `number_of_channels`=2 and `rx_out` always 8'b1100_1100 → no slips; after 4 matching strobes per channel, `aligned`=2'b11, `done`=1, and `rx_channel_data_align` is never high.
- **DPA off, two slips**: ch0 word stays wrong until the 2nd slip → exactly 2 rising edges on `rx_channel_data_align[0]`, then `aligned[0]`=1.
- **DPA on, lock timeout**: `rx_dpa_locked` tied 0 with `lock_timeout`=8 → `rx_dpll_reset[0]` high for 4 cycles; `align_error[0]`=1 after the 8th strobe; no FIFO or CDA reset for ch0; ch1 proceeds normally.
- **Slip exhaustion**: pattern never matches with `data_align_rollover`=4 → exactly 4 slips, then `align_error[ch]`=1 and `aligned[ch]`=0.
- **Reset mid-SLIP**: assert `rx_reset` during the 1st slip cycle → `rx_channel_data_align`=0, `busy`=0, `cur_channel`=0 on the next edge.
- **Start while busy**: `start` pulsed during CHECK → no restart, and `aligned`/`align_error` are not cleared.
